// File: rtl/alu_pkg.sv
// Shared opcode constants, command record, FSM state type and latency helper
// for the ALU issue controller.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_POW = 3'b101;
  localparam logic [2:0] OP_RS  = 3'b110;
  localparam logic [2:0] OP_LS  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } cmd_t;

  // Settle cycles the downstream ALU needs before its output may be sampled.
  function automatic int unsigned lat(input logic [2:0] op, input int unsigned mc_cycles);
    case (op)
      OP_ADD, OP_SUB, OP_RS, OP_LS: return 1;
      default:                      return mc_cycles;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command buffer for the ALU issue controller: power-of-two depth, no bypass,
// a push into a full buffer is refused even when a pop happens in the same cycle.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 67
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues buffered commands one at a time to an external combinational ALU and
// returns registered results. Optional macro: ALU_DIVZERO_CHK_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MC_CYCLES  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_cs,
  input  logic [31:0] alu_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic [2:0]  out_op,
  output logic        out_err,
  output logic        busy,
  output state_e      dbg_state_o
);

  localparam int CNT_W = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the payload holds until the transfer.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d, out_y_q, out_y_d;
  logic [2:0]       op_q, op_d, out_op_q, out_op_d;
  logic             divz_q, divz_d, out_err_q, out_err_d, out_valid_q, out_valid_d;
  logic             fifo_full, fifo_empty, pop;
  logic             head_divz;
  cmd_t             head, in_cmd;

  assign in_cmd = '{a: in_a, b: in_b, op: in_op};

  alu_cmd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(cmd_t))
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (in_valid),
    .wdata_i(in_cmd),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

`ifdef ALU_DIVZERO_CHK_EN
  assign head_divz = ((head.op == OP_DIV) || (head.op == OP_MOD)) && (head.b == '0);
`else
  assign head_divz = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    divz_d      = divz_q;
    out_y_d     = out_y_q;
    out_op_d    = out_op_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          a_d     = head.a;
          b_d     = head.b;
          op_d    = head.op;
          divz_d  = head_divz;
          cnt_d   = head_divz ? '0 : CNT_W'(lat(head.op, MC_CYCLES) - 1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          out_y_d     = divz_q ? '0 : alu_y;
          out_op_d    = op_q;
          out_err_d   = divz_q;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      divz_q      <= 1'b0;
      out_y_q     <= '0;
      out_op_q    <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      divz_q      <= divz_d;
      out_y_q     <= out_y_d;
      out_op_q    <= out_op_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_cs      = op_q;
  assign out_valid   = out_valid_q;
  assign out_y       = out_y_q;
  assign out_op      = out_op_q;
  assign out_err     = out_err_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: expected results are queued at acceptance
// and checked by a monitor whenever a result is handed over.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int MC    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [2:0]  in_op = '0;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_cs;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_y;
  logic [2:0]  out_op;
  logic        out_err;
  logic        busy;
  state_e      dbg_state;

  logic [35:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  alu_issue_ctrl #(.FIFO_DEPTH(DEPTH), .MC_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cs(alu_cs), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_op(out_op),
    .out_err(out_err), .busy(busy), .dbg_state_o(dbg_state)
  );

  // Reference for the external combinational ALU the block drives.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] r;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_MUL: r = a * b;
      OP_DIV: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_MOD: r = (b == 0) ? a : a % b;
      OP_POW: begin
        r = 32'd1;
        for (int i = 0; i < 32; i++) if (i < b) r = r * a;
      end
      OP_RS:  r = a >> b[4:0];
      default: r = a << b[4:0];
    endcase
    return r;
  endfunction

  assign alu_y = ref_alu(alu_a, alu_b, alu_cs);

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // driver: present a command and hold it until accepted
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] y, input logic err);
    bit acc;
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    for (int i = 0; i < 100 && !done; i++) begin
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        done = 1'b1;
        exp_q.push_back({err, op, y});
      end
      step();
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 36'd0, 36'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || dbg_state != ST_IDLE || busy) && i < 300) begin
      step();
      i++;
    end
    check(name, {31'd0, exp_q.size() == 0, busy}, 36'd2);
  endtask

  // scoreboard monitor
  logic        hold_valid = 1'b0;
  logic [35:0] hold_val;
  initial begin
    logic [35:0] got, e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        hold_valid = 1'b0;
      end else if (out_valid) begin
        got = {out_err, out_op, out_y};
        if (hold_valid) check("stable_under_stall", got, hold_val);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", got, 36'hF_FFFF_FFFF ^ got);
          end else begin
            e = exp_q.pop_front();
            check("result", got, e);
          end
          hold_valid = 1'b0;
        end else begin
          hold_valid = 1'b1;
          hold_val = got;
        end
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] dz_y;
    logic        dz_err;
    int          dz_lat;
    logic [31:0] va[8], vb[8], vy[8];
    logic [2:0]  vo[8];
`ifdef ALU_DIVZERO_CHK_EN
    dz_y = 32'd0; dz_err = 1'b1; dz_lat = 2;
`else
    dz_y = 32'hFFFF_FFFF; dz_err = 1'b0; dz_lat = MC + 1;
`endif
    va = '{32'd3, 32'd100, 32'd100, 32'd3, 32'h80, 32'd1, 32'hFFFF_FFFF, 32'h1_0000};
    vb = '{32'd5, 32'd7, 32'd7, 32'd4, 32'd3, 32'd31, 32'd1, 32'h1_0000};
    vo = '{OP_SUB, OP_DIV, OP_MOD, OP_POW, OP_RS, OP_LS, OP_ADD, OP_MUL};
    vy = '{32'hFFFF_FFFE, 32'd14, 32'd2, 32'd81, 32'h10, 32'h8000_0000, 32'd0, 32'd0};

    // reset values
    step();
    step();
    check("rst_in_ready", {35'd0, in_ready}, 36'd1);
    check("rst_out_valid", {35'd0, out_valid}, 36'd0);
    check("rst_busy", {35'd0, busy}, 36'd0);
    check("rst_out_err", {35'd0, out_err}, 36'd0);
    check("rst_regs", {alu_cs, out_y}, 36'd0);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;

    // ADD latency and value
    push(32'd5, 32'd7, OP_ADD, 32'd12, 1'b0);
    wait_valid(n);
    check("add_latency", 36'(n), 36'd2);
    drain("add_drain");

    // MUL latency and value
    push(32'd6, 32'd7, OP_MUL, 32'd42, 1'b0);
    wait_valid(n);
    check("mul_latency", 36'(n), 36'(MC + 1));
    drain("mul_drain");

    // DIV by zero
    push(32'd9, 32'd0, OP_DIV, dz_y, dz_err);
    wait_valid(n);
    check("divz_latency", 36'(n), 36'(dz_lat));
    drain("divz_drain");

    // one of each opcode back to back
    for (int i = 0; i < 8; i++) push(va[i], vb[i], vo[i], vy[i], 1'b0);
    drain("mix_drain");

    // backpressure: 1 command held in DONE plus 4 buffered
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'(i), 32'd100, OP_ADD, 32'(100 + i), 1'b0);
    check("bp_in_ready_low", {35'd0, in_ready}, 36'd0);
    step();
    step();
    check("bp_still_full", {34'd0, in_ready, out_valid}, 36'd1);
    out_ready = 1'b1;
    push(32'd5, 32'd100, OP_ADD, 32'd105, 1'b0);
    drain("bp_drain");

    // pointer wrap with back-to-back SUBs
    for (int i = 0; i < 10; i++) push(32'd100, 32'(i), OP_SUB, 32'(100 - i), 1'b0);
    drain("wrap_drain");

    // reset while POW executes with two commands queued
    push(32'd2, 32'd10, OP_POW, 32'd1024, 1'b0);
    push(32'd1, 32'd1, OP_ADD, 32'd2, 1'b0);
    push(32'd2, 32'd2, OP_ADD, 32'd4, 1'b0);
    check("rst_mid_in_exec", 36'(dbg_state), 36'(ST_EXEC));
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {35'd0, out_valid}, 36'd0);
    check("rst_mid_busy", {35'd0, busy}, 36'd0);
    check("rst_mid_in_ready", {35'd0, in_ready}, 36'd1);
    check("rst_mid_alu_a", {4'd0, alu_a}, 36'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("post_rst_idle", {34'd0, busy, out_valid}, 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
